// File: rtl/hex_scan_display.sv
// hex_scan_display: four-digit time-multiplexed seven-segment scan driver.
// Digit values are latched into a shadow register once per frame, so the
// display never shows a half-updated number. Each slot opens with a short
// blanking guard that suppresses ghosting between digits.
module hex_scan_display #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_in,
    input  logic       lz_en,
    input  logic       en,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig,
    output logic       frame_start
);

    localparam int unsigned    CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
    localparam logic [6:0]     SEG_POL   = {7{ACTIVE_LOW}};
    localparam logic [3:0]     DIG_POL   = {4{ACTIVE_LOW}};

    // Hex digit to segment pattern, active-high, bit0 = segment a.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0:    hex_decode = 7'h3F;
            4'h1:    hex_decode = 7'h06;
            4'h2:    hex_decode = 7'h5B;
            4'h3:    hex_decode = 7'h4F;
            4'h4:    hex_decode = 7'h66;
            4'h5:    hex_decode = 7'h6D;
            4'h6:    hex_decode = 7'h7D;
            4'h7:    hex_decode = 7'h07;
            4'h8:    hex_decode = 7'h7F;
            4'h9:    hex_decode = 7'h6F;
            4'hA:    hex_decode = 7'h77;
            4'hB:    hex_decode = 7'h7C;
            4'hC:    hex_decode = 7'h39;
            4'hD:    hex_decode = 7'h5E;
            4'hE:    hex_decode = 7'h79;
            4'hF:    hex_decode = 7'h71;
            default: hex_decode = 7'h00;
        endcase
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  sh_q, sh_d;
    logic [3:0]       dp_sh_q, dp_sh_d;
    logic             load_pend_q, load_pend_d;
    logic             fs_q, fs_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       dig_q, dig_d;

    logic             wrap_s;
    logic             boundary_s;
    logic             load_s;
    logic [3:0]       blank_s;
    logic             active_s;
    logic [6:0]       seg_l_s;
    logic             dp_l_s;
    logic [3:0]       dig_l_s;

    assign wrap_s     = (cnt_q == CNT_MAX);
    assign boundary_s = wrap_s && (idx_q == 2'd3);
    // The pending flag forces one capture right after reset release.
    assign load_s     = boundary_s || load_pend_q;

    // Prescaler, slot index, shadow capture and frame pulse next-state.
    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        dp_sh_d     = dp_sh_q;
        load_pend_d = 1'b0;
        fs_d        = boundary_s;
        if (wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (load_s) begin
            sh_d    = {digit3, digit2, digit1, digit0};
            dp_sh_d = dp_in;
        end else begin
            sh_d    = sh_q;
            dp_sh_d = dp_sh_q;
        end
    end

    // Leading-zero chain: a digit blanks only when it and every higher digit are zero.
    always_comb begin
        blank_s    = 4'b0000;
        blank_s[3] = (sh_q[3] == 4'h0);
        blank_s[2] = blank_s[3] && (sh_q[2] == 4'h0);
        blank_s[1] = blank_s[2] && (sh_q[1] == 4'h0);
        blank_s[0] = 1'b0;
    end

    assign active_s = en && (cnt_q >= BLANK_LIM);

    // Logical (active-high) drive for the current slot, then output polarity.
    always_comb begin
        seg_l_s = 7'h00;
        dp_l_s  = 1'b0;
        dig_l_s = 4'b0000;
        if (active_s) begin
            dig_l_s = 4'b0001 << idx_q;
            if (lz_en && blank_s[idx_q]) begin
                seg_l_s = 7'h00;
                dp_l_s  = 1'b0;
            end else begin
                seg_l_s = hex_decode(sh_q[idx_q]);
                dp_l_s  = dp_sh_q[idx_q];
            end
        end else begin
            seg_l_s = 7'h00;
            dp_l_s  = 1'b0;
            dig_l_s = 4'b0000;
        end
        seg_d = seg_l_s ^ SEG_POL;
        dp_d  = dp_l_s ^ ACTIVE_LOW;
        dig_d = dig_l_s ^ DIG_POL;
    end

    // State and registered outputs; reset drives every display pin inactive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= {CNT_W{1'b0}};
            idx_q       <= 2'd0;
            sh_q        <= '0;
            dp_sh_q     <= 4'b0000;
            load_pend_q <= 1'b1;
            fs_q        <= 1'b0;
            seg_q       <= SEG_POL;
            dp_q        <= ACTIVE_LOW;
            dig_q       <= DIG_POL;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            dp_sh_q     <= dp_sh_d;
            load_pend_q <= load_pend_d;
            fs_q        <= fs_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            dig_q       <= dig_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign dig         = dig_q;
    assign frame_start = fs_q;

endmodule
